// File: rtl/signal_timer_if.sv
// Bus between signal_timer and light_controller: state code and priority requests in,
// dwell-complete pulse, phase choice and pending flags out. No backpressure on this bus.
interface signal_timer_if;
    logic [3:0] current_state;
    logic       east_req;
    logic       west_req;
    logic       timing_done;
    logic [1:0] phase;
    logic [1:0] req_pending;

    modport master (
        output current_state,
        output east_req,
        output west_req,
        input  timing_done,
        input  phase,
        input  req_pending
    );

    modport slave (
        input  current_state,
        input  east_req,
        input  west_req,
        output timing_done,
        output phase,
        output req_pending
    );
endinterface

// File: rtl/signal_timer.sv
// Per-state dwell timer and phase scheduler for light_controller; timing_done fires in dwell cycle D-1,
// phase is registered one cycle after ALL_RED entry. All outputs registered; no backpressure.
module signal_timer #(
    parameter int GREEN_TICKS      = 20,
    parameter int PRIO_GREEN_TICKS = 12,
    parameter int YELLOW_TICKS     = 4,
    parameter int RED_TICKS        = 2,
    parameter int CNT_W            = 8
) (
    input  logic          clk,
    input  logic          rst,
    signal_timer_if.slave bus
);

    localparam logic [3:0] ST_ALL_RED        = 4'd0;
    localparam logic [3:0] ST_PHASE_1_GREEN  = 4'd1;
    localparam logic [3:0] ST_PHASE_1_YELLOW = 4'd2;
    localparam logic [3:0] ST_PHASE_2_GREEN  = 4'd3;
    localparam logic [3:0] ST_PHASE_2_YELLOW = 4'd4;
    localparam logic [3:0] ST_EAST_GREEN     = 4'd5;
    localparam logic [3:0] ST_EAST_YELLOW    = 4'd6;
    localparam logic [3:0] ST_WEST_GREEN     = 4'd7;
    localparam logic [3:0] ST_WEST_YELLOW    = 4'd8;
    localparam logic [3:0] ST_NONE           = 4'hF;

    typedef enum logic [1:0] {
        PHASE_1       = 2'd0,
        PHASE_2       = 2'd1,
        EAST_PRIORITY = 2'd2,
        WEST_PRIORITY = 2'd3
    } phase_e;

    logic [3:0]       last_state_q, last_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timing_done_q, timing_done_d;
    phase_e           phase_q, phase_d;
    logic [1:0]       pend_q, pend_d;
    phase_e           last_normal_q, last_normal_d;
    logic             last_prio_west_q, last_prio_west_d;

    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] rem;
    logic             entry;
    logic             timed;
    logic             eff_east;
    logic             eff_west;

    always_comb begin
        dwell = '0;
        case (bus.current_state)
            ST_PHASE_1_GREEN, ST_PHASE_2_GREEN:                         dwell = CNT_W'(GREEN_TICKS);
            ST_EAST_GREEN, ST_WEST_GREEN:                               dwell = CNT_W'(PRIO_GREEN_TICKS);
            ST_PHASE_1_YELLOW, ST_PHASE_2_YELLOW,
            ST_EAST_YELLOW, ST_WEST_YELLOW:                             dwell = CNT_W'(YELLOW_TICKS);
            ST_ALL_RED:                                                 dwell = CNT_W'(RED_TICKS);
            default:                                                    dwell = '0;
        endcase
    end

    always_comb begin
        entry = (bus.current_state != last_state_q);
        timed = (dwell != '0);
        last_state_d = bus.current_state;

        // rem is the number of cycles left after this one: D-1-k in dwell cycle k.
        if (entry) begin
            rem = timed ? (dwell - CNT_W'(1)) : '0;
        end else begin
            rem = cnt_q;
        end
        cnt_d         = (rem == '0) ? '0 : (rem - CNT_W'(1));
        timing_done_d = timed && (rem == CNT_W'(1));

        // A new request on a clearing entry survives: set wins.
        pend_d[1] = bus.east_req | (pend_q[1] & ~(entry && bus.current_state == ST_EAST_GREEN));
        pend_d[0] = bus.west_req | (pend_q[0] & ~(entry && bus.current_state == ST_WEST_GREEN));

        eff_east = pend_q[1] | bus.east_req;
        eff_west = pend_q[0] | bus.west_req;

        phase_d          = phase_q;
        last_normal_d    = last_normal_q;
        last_prio_west_d = last_prio_west_q;
        if (entry && bus.current_state == ST_ALL_RED) begin
            if (eff_east && !eff_west) begin
                phase_d          = EAST_PRIORITY;
                last_prio_west_d = 1'b0;
            end else if (eff_west && !eff_east) begin
                phase_d          = WEST_PRIORITY;
                last_prio_west_d = 1'b1;
            end else if (eff_east && eff_west) begin
                phase_d          = last_prio_west_q ? EAST_PRIORITY : WEST_PRIORITY;
                last_prio_west_d = ~last_prio_west_q;
            end else begin
                phase_d       = (last_normal_q == PHASE_2) ? PHASE_1 : PHASE_2;
                last_normal_d = phase_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_state_q     <= ST_NONE;
            cnt_q            <= '0;
            timing_done_q    <= 1'b0;
            phase_q          <= PHASE_1;
            pend_q           <= 2'b00;
            last_normal_q    <= PHASE_2;
            last_prio_west_q <= 1'b1;
        end else begin
            last_state_q     <= last_state_d;
            cnt_q            <= cnt_d;
            timing_done_q    <= timing_done_d;
            phase_q          <= phase_d;
            pend_q           <= pend_d;
            last_normal_q    <= last_normal_d;
            last_prio_west_q <= last_prio_west_d;
        end
    end

    assign bus.timing_done = timing_done_q;
    assign bus.phase       = phase_q;
    assign bus.req_pending = pend_q;

endmodule

// File: tb/tb_signal_timer.sv
// Directed bench for signal_timer: drives a controller-like state sequence and checks
// the dwell pulse, phase decisions and pending flags against hand-computed values.
module tb_signal_timer;

    localparam logic [3:0] AR  = 4'd0;
    localparam logic [3:0] P1G = 4'd1;
    localparam logic [3:0] P1Y = 4'd2;
    localparam logic [3:0] P2G = 4'd3;
    localparam logic [3:0] P2Y = 4'd4;
    localparam logic [3:0] EG  = 4'd5;
    localparam logic [3:0] EY  = 4'd6;
    localparam logic [3:0] WG  = 4'd7;
    localparam logic [3:0] WY  = 4'd8;
    localparam logic [3:0] MNT = 4'd9;

    localparam logic [1:0] PH1 = 2'd0;
    localparam logic [1:0] PH2 = 2'd1;
    localparam logic [1:0] PE  = 2'd2;
    localparam logic [1:0] PW  = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    signal_timer_if ifc();

    signal_timer #(
        .GREEN_TICKS      (20),
        .PRIO_GREEN_TICKS (12),
        .YELLOW_TICKS     (4),
        .RED_TICKS        (2),
        .CNT_W            (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds state st for 'cycles' cycles; the pulse is expected only in cycle d-1.
    task automatic dwell(input string tag, input logic [3:0] st, input int d, input int cycles,
                         input logic [1:0] eph, input int e_at, input int w_at);
        for (int k = 0; k < cycles; k++) begin
            ifc.current_state = st;
            ifc.east_req      = (k == e_at);
            ifc.west_req      = (k == w_at);
            check($sformatf("%s.done[%0d]", tag, k), {3'b000, ifc.timing_done}, {3'b000, (k == d - 1)});
            if (st != AR || k >= 1)
                check($sformatf("%s.phase[%0d]", tag, k), {2'b00, ifc.phase}, {2'b00, eph});
            cyc();
        end
        ifc.east_req = 1'b0;
        ifc.west_req = 1'b0;
    endtask

    task automatic chk_pend(input string tag, input logic [1:0] exp);
        check(tag, {2'b00, ifc.req_pending}, {2'b00, exp});
    endtask

    initial begin
        rst               = 1'b0;
        ifc.current_state = MNT;
        ifc.east_req      = 1'b0;
        ifc.west_req      = 1'b0;
        #1;
        check("rst.done",  {3'b000, ifc.timing_done}, 4'd0);
        check("rst.phase", {2'b00, ifc.phase}, {2'b00, PH1});
        check("rst.pend",  {2'b00, ifc.req_pending}, 4'd0);
        cyc();
        cyc();
        rst = 1'b1;

        // Normal rotation with a one-cycle east request in PHASE_2_GREEN.
        dwell("ar1", AR,  2,  2, PH1, -1, -1);
        dwell("p1g", P1G, 20, 20, PH1, -1, -1);
        dwell("p1y", P1Y, 4,  4, PH1, -1, -1);
        dwell("ar2", AR,  2,  2, PH2, -1, -1);
        dwell("p2g", P2G, 20, 20, PH2, 5, -1);
        chk_pend("pend.east", 2'b10);
        dwell("p2y", P2Y, 4,  4, PH2, -1, -1);
        dwell("ar3", AR,  2,  2, PE, -1, -1);
        dwell("eg1", EG,  12, 12, PE, -1, -1);
        chk_pend("pend.eclr", 2'b00);
        dwell("ey1", EY,  4,  4, PE, -1, -1);
        dwell("ar4", AR,  2,  2, PH1, -1, -1);

        // Both requests together; east was served last so west goes first.
        dwell("p1g2", P1G, 20, 20, PH1, 3, 3);
        chk_pend("pend.both", 2'b11);
        dwell("p1y2", P1Y, 4, 4, PH1, -1, -1);
        dwell("ar5", AR,  2,  2, PW, -1, -1);
        dwell("wg1", WG,  12, 12, PW, -1, -1);
        chk_pend("pend.wclr", 2'b10);
        dwell("wy1", WY,  4,  4, PW, -1, -1);
        dwell("ar6", AR,  2,  2, PE, -1, -1);
        dwell("eg2", EG,  12, 12, PE, -1, -1);
        chk_pend("pend.eclr2", 2'b00);
        dwell("ey2", EY,  4,  4, PE, -1, -1);
        dwell("ar7", AR,  2,  2, PH2, -1, -1);
        dwell("p2g2", P2G, 20, 20, PH2, -1, -1);
        dwell("p2y2", P2Y, 4, 4, PH2, -1, -1);

        // Request on the ALL_RED entry cycle joins that decision; request on WG entry survives the clear.
        dwell("ar8", AR,  2,  2, PW, -1, 0);
        chk_pend("pend.arw", 2'b01);
        dwell("wg2", WG,  12, 12, PW, -1, 0);
        chk_pend("pend.setwins", 2'b01);
        dwell("wy2", WY,  4,  4, PW, -1, -1);
        dwell("ar9", AR,  2,  2, PW, -1, -1);
        dwell("wg3", WG,  12, 12, PW, -1, -1);
        chk_pend("pend.wclr2", 2'b00);
        dwell("wy3", WY,  4,  4, PW, -1, -1);

        // Maintenance: no pulses, phase holds, requests still latched.
        dwell("mnt", MNT, 0, 50, PW, 10, -1);
        chk_pend("pend.mnt", 2'b10);
        dwell("ar10", AR, 2,  2, PE, -1, -1);
        dwell("eg3", EG,  12, 12, PE, -1, -1);
        dwell("ey3", EY,  4,  4, PE, -1, -1);
        dwell("ar11", AR, 2,  2, PH1, -1, -1);

        // Stalled controller: one pulse at cycle 19, then silence.
        dwell("stall", P1G, 20, 60, PH1, -1, -1);
        dwell("p1y3", P1Y, 4, 4, PH1, -1, -1);
        dwell("ar12", AR, 2,  2, PH2, -1, -1);
        dwell("p2g3", P2G, 20, 20, PH2, -1, -1);
        dwell("p2y3", P2Y, 4, 4, PH2, -1, -1);
        dwell("ar13", AR, 2,  2, PW, -1, 0);

        // Asynchronous reset in the middle of WESTBOUND_GREEN with east pending.
        dwell("wg4", WG,  12, 5, PW, 1, -1);
        chk_pend("pend.prerst", 2'b10);
        #3;
        rst = 1'b0;
        #1;
        check("arst.done",  {3'b000, ifc.timing_done}, 4'd0);
        check("arst.phase", {2'b00, ifc.phase}, {2'b00, PH1});
        check("arst.pend",  {2'b00, ifc.req_pending}, 4'd0);
        cyc();
        rst = 1'b1;
        dwell("ar14", AR, 2,  2, PH1, -1, -1);
        chk_pend("pend.postrst", 2'b00);
        dwell("p1g4", P1G, 20, 20, PH1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_timer.md
# signal_timer

Timing and phase-scheduling stage directly upstream of `light_controller`. It watches the controller's `current_state`, counts the programmed dwell for each state, and pulses `timing_done` so the controller advances. It also chooses the `phase` the controller uses when it leaves `ALL_RED`: normal `PHASE_1`/`PHASE_2` alternation, overridden by latched eastbound/westbound priority requests.

## Interface
- `GREEN_TICKS`, 20: dwell in cycles for `PHASE_1_GREEN` and `PHASE_2_GREEN`.
- `PRIO_GREEN_TICKS`, 12: dwell for `EASTBOUND_GREEN` and `WESTBOUND_GREEN`.
- `YELLOW_TICKS`, 4: dwell for every yellow state.
- `RED_TICKS`, 2: dwell for `ALL_RED`.
- `CNT_W`, 8: counter width. Every `*_TICKS` value is at least 2 and at most 2^CNT_W−1.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `current_state`  in  4  state code from `light_controller`, using the codes in `fsm_parameters.v`.
- `east_req`  in  1  eastbound priority request; a one-cycle pulse or a level.
- `west_req`  in  1  westbound priority request; a one-cycle pulse or a level.
- `timing_done`  out  1  registered one-cycle dwell-complete pulse.
- `phase`  out  2  registered phase code: `PHASE_1`, `PHASE_2`, `EAST_PRIORITY` or `WEST_PRIORITY`.
- `req_pending`  out  2  registered pending-request flags: bit 1 = east, bit 0 = west.

## Operation
- **State tracking**
  - Register `last_state`. Its reset value is the reserved code 4'hF, which no state uses.
  - Entry cycle: any cycle with `current_state != last_state`. Dwell cycle k = 0 is the entry cycle.
- **Dwell D per state**
  - Green states: `GREEN_TICKS` or `PRIO_GREEN_TICKS`, as listed above.
  - Yellow states: `YELLOW_TICKS`. `ALL_RED`: `RED_TICKS`.
  - `MAINTENANCE` or any unlisted code: no dwell. The counter is idle and `timing_done` stays 0.
- **Counter**
  - Down-counter, loaded on the entry cycle and decremented each following cycle. It saturates at 0 and never wraps.
  - `timing_done` is high in exactly dwell cycle D−1 and low in every other cycle.
  - The controller samples `timing_done` at the edge that ends cycle D−1, so every timed state occupies exactly D cycles.
- **Stall**: if `current_state` does not change after the pulse, the counter stays at 0 and no further pulse is issued until the next entry.
- **Request latching**
  - `req_pending[1]` is set by `east_req`; `req_pending[0]` is set by `west_req`.
  - Entry into `EASTBOUND_GREEN` clears the east flag; entry into `WESTBOUND_GREEN` clears the west flag.
  - Set and clear in the same cycle: set wins.
- **Phase decision**: made on every `ALL_RED` entry cycle and registered. The result is valid from dwell cycle 1 and held until the next `ALL_RED` entry. Selection order:
  - Only east pending: `EAST_PRIORITY`.
  - Only west pending: `WEST_PRIORITY`.
  - Both pending: the side not served last, tracked by register `last_prio`. `last_prio` resets to west, so east goes first.
  - Neither pending: the opposite of `last_normal`. `last_normal` resets to `PHASE_2`.
  - `last_normal` updates when a normal phase is issued; `last_prio` updates when a priority phase is issued.
- **Late requests**: a request arriving after the `ALL_RED` entry cycle does not change `phase` until the next `ALL_RED` entry.
- **Maintenance**: `phase` and the pending flags hold; new requests are still latched. Leaving `MAINTENANCE` to `ALL_RED` is a normal entry.

## Timing
- **Reset values** (asynchronous, effective while `rst`=0)
  - `timing_done`=0, `req_pending`=2'b00, `phase`=`PHASE_1`.
  - Counter = 0, `last_state`=4'hF, `last_normal`=`PHASE_2`, `last_prio`=west.
- **Reset mid-operation**: every register returns to its reset value immediately and pending flags are lost. The first cycle after release with `current_state`=`ALL_RED` is an entry, so `timing_done` pulses RED_TICKS−1 cycles later.
- **Latency**
  - `timing_done` rises D−1 cycles after the entry cycle.
  - `phase` updates 1 cycle after the `ALL_RED` entry. RED_TICKS ≥ 2 guarantees it is stable when `timing_done` fires.
  - `req_pending` sets 1 cycle after the request.
- **Simultaneous events**: a request arriving on an `ALL_RED` entry cycle is included in that cycle's phase decision (combinational merge of new request and flag).

## Test plan
1. Reset, no requests, defaults → `ALL_RED` 2 cycles, `PHASE_1_GREEN` 20, `PHASE_1_YELLOW` 4, `ALL_RED` 2, `PHASE_2_GREEN` 20. Exactly one `timing_done` pulse per state, and `phase` alternates `PHASE_1` → `PHASE_2`.
2. `east_req` pulse during `PHASE_1_GREEN` → `req_pending`=2'b10. The next `ALL_RED` gives `EAST_PRIORITY`, `EASTBOUND_GREEN` lasts 12 cycles, `req_pending`=2'b00 after entry, and the following red gives `PHASE_2`.
3. `east_req` and `west_req` in the same cycle → the next two reds give `EAST_PRIORITY` then `WEST_PRIORITY`, and normal rotation then resumes.
4. `current_state`=`MAINTENANCE` for 50 cycles, then `ALL_RED` → no `timing_done` during maintenance. Exactly one pulse in `ALL_RED` cycle 1.
5. `rst` low mid-`WESTBOUND_GREEN` with east pending → all outputs take their reset values without waiting for a clock edge, and `req_pending`=0.
6. `current_state` held at `PHASE_1_GREEN` for 60 cycles → a single pulse at cycle 19, then `timing_done` stays 0.
